dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Data-memory controller that executes the memory operations the instruction decoder requests through its Mem_we / Mem_rd_sel encodings.
- Accepts one load/store from the execute stage per valid/ready handshake, then drives a single-port synchronous word SRAM.
- Performs byte-lane steering on stores, and lane extraction plus sign/zero extension on loads.
- Returns the result, or a misalignment error, on a held response channel with back-pressure.

Parameters:
ADDR_W, 10, SRAM word-address width (depth = 2^ADDR_W words of 32 bits)

Ports:
Clk  in  1  system clock, rising edge
Rst_n  in  1  reset, asynchronous, active-low
Req_valid  in  1  memory request present
Req_ready  out  1  controller can accept a request
Req_addr  in  32  byte address (ALU result)
Req_wdata  in  32  store data (rs2)
Req_we  in  2  store width; WR_OFF means load
Req_rd_sel  in  3  load format, used when Req_we = WR_OFF
Rsp_valid  out  1  response present
Rsp_ready  in  1  consumer accepts response
Rsp_rdata  out  32  formatted load data; 0 for stores and errors
Rsp_err  out  1  misaligned access; no SRAM access was made
Sram_en  out  1  SRAM access strobe
Sram_we  out  4  per-byte write enables
Sram_addr  out  ADDR_W  word address = Req_addr[ADDR_W+1:2]
Sram_wdata  out  32  lane-steered store data
Sram_rdata  in  32  read data, valid the cycle after Sram_en with Sram_we = 0

Behaviour:
- Encodings:
  - Req_we: WR_OFF=0, WR_BYTE=1, WR_HWORD=2, WR_WORD=3.
  - Req_rd_sel: 0 word, 1 RD_BYTE, 2 RD_HWORD, 3 RD_BYTE_U, 4 RD_HWORD_U; codes 5–7 are treated as word.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - Req_ready = 1; Rsp_valid, Rsp_err, Sram_en, Sram_we, Sram_addr, Sram_wdata = 0; Rsp_rdata = 0.
  - A write in flight is dropped; Sram_en falls immediately.
- States: IDLE, ACCESS, LATCH, RESP.
- IDLE:
  - Req_ready = 1.
  - On Req_valid, register addr, wdata, we and rd_sel.
  - If misaligned (HWORD/half-load with addr[0]=1; WORD/word-load with addr[1:0]≠0): go to RESP with Rsp_err=1 and Rsp_rdata=0.
  - Otherwise go to ACCESS.
- ACCESS, one cycle:
  - Sram_en=1, Sram_addr from the registered address.
  - Store: Sram_we = 4'b0001<<a[1:0] (byte), 4'b0011<<a[1:0] (half), or 4'b1111 (word); Sram_wdata = byte or half replicated across lanes. Next state RESP with Rsp_rdata=0.
  - Load: Sram_we=0; next state LATCH.
- LATCH, one cycle:
  - Select lane a[1:0] (byte) or a[1] (half) of Sram_rdata.
  - Sign-extend for RD_BYTE/RD_HWORD, zero-extend for the _U variants, pass the full word otherwise.
  - Register the result into Rsp_rdata; go to RESP.
- RESP:
  - Rsp_valid=1; Rsp_rdata and Rsp_err are held stable until Rsp_ready.
  - On Rsp_ready, return to IDLE; Rsp_valid drops the next cycle.
  - Req_ready=0 in every state except IDLE, so no overlap of requests.
- Latency from the accept edge to the first Rsp_valid cycle: load 3 cycles, store 2, error 1.
  - With Rsp_ready held high, each request occupies this latency + 1 cycles; there is no back-to-back pipelining.
- Sram_en and Sram_we are 0 outside ACCESS, so the SRAM is never written twice.
- Address bits above ADDR_W+1 are ignored, so accesses wrap modulo the SRAM size.

Decomposition:
- defines.v gains the RD_* codes (WR_* already present), the state encodings, and the misalign rules as macros.
- One combinational sub-module, dmem_lane, handles:
  - store byte-enable and data steering;
  - load lane extraction and extension.
- dmem_ctrl holds the FSM and all registers.

Test Plan:
- SW addr 0x10, data 0xDEADBEEF → ACCESS shows Sram_addr=4, Sram_we=1111, Sram_wdata=0xDEADBEEF; Rsp_valid 2 cycles after accept with Rsp_rdata=0 and Rsp_err=0.
- SB addr 0x13, data 0x000000A5, then LB addr 0x13 → Sram_we=1000 and Sram_wdata=0xA5A5A5A5; the load returns 0xFFFFFFA5, and LBU at the same address returns 0x000000A5.
- SH addr 0x22, data 0x8001, then LH / LHU / LW at 0x22 / 0x22 / 0x20 → Sram_we=1100; results 0xFFFF8001, 0x00008001, and 0x8001xxxx with the low half unchanged.
- LW at 0x06 and SH at 0x05 → Rsp_err=1, Rsp_rdata=0, Rsp_valid 1 cycle after accept, Sram_en never asserted.
- Load with Rsp_ready held low for 5 cycles → Rsp_valid/Rsp_rdata stable throughout and Req_ready=0; the next request is accepted the cycle after the Rsp_ready handshake.
- Rst_n asserted during ACCESS of a SW → Sram_en and Sram_we drop immediately; all outputs at reset values; after release Req_ready=1 and a following LW reads the old memory contents.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings for the data-memory controller: store widths, load formats,
// FSM states and the alignment rule used at request accept.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    WR_OFF   = 2'd0,
    WR_BYTE  = 2'd1,
    WR_HWORD = 2'd2,
    WR_WORD  = 2'd3
  } wr_e;

  // Load formats; codes 5..7 fall through to a plain word load.
  localparam logic [2:0] RD_WORD    = 3'd0;
  localparam logic [2:0] RD_BYTE    = 3'd1;
  localparam logic [2:0] RD_HWORD   = 3'd2;
  localparam logic [2:0] RD_BYTE_U  = 3'd3;
  localparam logic [2:0] RD_HWORD_U = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_LATCH  = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  function automatic logic misaligned(input wr_e we, input logic [2:0] rd_sel,
                                      input logic [1:0] off);
    logic is_half;
    logic is_word;
    if (we != WR_OFF) begin
      is_half = (we == WR_HWORD);
      is_word = (we == WR_WORD);
    end else begin
      is_half = (rd_sel == RD_HWORD) || (rd_sel == RD_HWORD_U);
      is_word = !(is_half || rd_sel == RD_BYTE || rd_sel == RD_BYTE_U);
    end
    return (is_half && off[0]) || (is_word && (off != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_ctrl_lane.sv
// Combinational byte-lane logic: store byte enables and data replication,
// load lane extraction with sign or zero extension.
module dmem_lane
  import dmem_ctrl_pkg::*;
(
  input  logic [1:0]  off,
  input  wr_e         we,
  input  logic [31:0] wdata,
  input  logic [2:0]  rd_sel,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] st_data,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // NOTE: every output of an always_comb gets a default first, otherwise a
  // path that skips an assignment infers a latch.
  always_comb begin
    be      = 4'b0000;
    st_data = wdata;
    case (we)
      WR_BYTE: begin
        be      = 4'b0001 << off;
        st_data = {4{wdata[7:0]}};
      end
      WR_HWORD: begin
        be      = 4'b0011 << off;
        st_data = {2{wdata[15:0]}};
      end
      WR_WORD: be = 4'b1111;
      default: ;
    endcase
  end

  always_comb begin
    byte_v = rdata[7:0];
    case (off)
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      2'd3:    byte_v = rdata[31:24];
      default: ;
    endcase
    half_v = off[1] ? rdata[31:16] : rdata[15:0];

    ld_data = rdata;
    case (rd_sel)
      RD_BYTE:    ld_data = {{24{byte_v[7]}}, byte_v};
      RD_HWORD:   ld_data = {{16{half_v[15]}}, half_v};
      RD_BYTE_U:  ld_data = {24'd0, byte_v};
      RD_HWORD_U: ld_data = {16'd0, half_v};
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: one request at a time through IDLE/ACCESS/LATCH/RESP,
// driving a single-port synchronous word SRAM and a held response channel.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Req_valid,
  output logic              Req_ready,
  input  logic [31:0]       Req_addr,
  input  logic [31:0]       Req_wdata,
  input  logic [1:0]        Req_we,
  input  logic [2:0]        Req_rd_sel,
  output logic              Rsp_valid,
  input  logic              Rsp_ready,
  output logic [31:0]       Rsp_rdata,
  output logic              Rsp_err,
  output logic              Sram_en,
  output logic [3:0]        Sram_we,
  output logic [ADDR_W-1:0] Sram_addr,
  output logic [31:0]       Sram_wdata,
  input  logic [31:0]       Sram_rdata
);

  state_e              state_q, state_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  wr_e                 we_q, we_d;
  logic [2:0]          rd_sel_q, rd_sel_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [3:0]          be;
  logic [31:0]         st_data;
  logic [31:0]         ld_data;
  logic                access;

  // Address bits above the SRAM range are ignored so accesses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^Req_addr[31:ADDR_W+2];

  dmem_lane u_lane (
    .off     (addr_q[1:0]),
    .we      (we_q),
    .wdata   (wdata_q),
    .rd_sel  (rd_sel_q),
    .rdata   (Sram_rdata),
    .be      (be),
    .st_data (st_data),
    .ld_data (ld_data)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    rd_sel_d = rd_sel_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (Req_valid) begin
          addr_d   = Req_addr[ADDR_W+1:0];
          wdata_d  = Req_wdata;
          we_d     = wr_e'(Req_we);
          rd_sel_d = Req_rd_sel;
          rdata_d  = 32'd0;
          err_d    = misaligned(wr_e'(Req_we), Req_rd_sel, Req_addr[1:0]);
          state_d  = err_d ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: state_d = (we_q == WR_OFF) ? S_LATCH : S_RESP;
      S_LATCH: begin
        rdata_d = ld_data;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (Rsp_ready) begin
          rdata_d = 32'd0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= WR_OFF;
      rd_sel_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      rd_sel_q <= rd_sel_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // SRAM strobes decode straight from the state so an async reset drops them at once.
  assign access     = (state_q == S_ACCESS);
  assign Sram_en    = access;
  assign Sram_we    = access ? be : 4'b0000;
  assign Sram_addr  = access ? addr_q[ADDR_W+1:2] : '0;
  assign Sram_wdata = (access && we_q != WR_OFF) ? st_data : 32'd0;

  assign Req_ready  = (state_q == S_IDLE);
  assign Rsp_valid  = (state_q == S_RESP);
  assign Rsp_rdata  = rdata_q;
  assign Rsp_err    = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a behavioural word SRAM model.
module tb_dmem_ctrl;

  localparam int ADDR_W = 10;

  logic              Clk = 1'b0;
  logic              Rst_n = 1'b0;
  logic              Req_valid = 1'b0;
  logic              Req_ready;
  logic [31:0]       Req_addr = '0;
  logic [31:0]       Req_wdata = '0;
  logic [1:0]        Req_we = '0;
  logic [2:0]        Req_rd_sel = '0;
  logic              Rsp_valid;
  logic              Rsp_ready = 1'b1;
  logic [31:0]       Rsp_rdata;
  logic              Rsp_err;
  logic              Sram_en;
  logic [3:0]        Sram_we;
  logic [ADDR_W-1:0] Sram_addr;
  logic [31:0]       Sram_wdata;
  logic [31:0]       Sram_rdata = '0;

  int checks = 0;
  int errors = 0;
  int en_count = 0;
  int en_snap;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  dmem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Req_valid  (Req_valid),
    .Req_ready  (Req_ready),
    .Req_addr   (Req_addr),
    .Req_wdata  (Req_wdata),
    .Req_we     (Req_we),
    .Req_rd_sel (Req_rd_sel),
    .Rsp_valid  (Rsp_valid),
    .Rsp_ready  (Rsp_ready),
    .Rsp_rdata  (Rsp_rdata),
    .Rsp_err    (Rsp_err),
    .Sram_en    (Sram_en),
    .Sram_we    (Sram_we),
    .Sram_addr  (Sram_addr),
    .Sram_wdata (Sram_wdata),
    .Sram_rdata (Sram_rdata)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (Sram_en) begin
      for (int i = 0; i < 4; i++)
        if (Sram_we[i]) mem[Sram_addr][8*i +: 8] <= Sram_wdata[8*i +: 8];
      Sram_rdata <= mem[Sram_addr];
      en_count++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Presents a request in IDLE, returns #1 after the accept edge.
  task automatic send(input string tag, input logic [1:0] we, input logic [2:0] rd,
                      input logic [31:0] addr, input logic [31:0] wd);
    Req_valid  = 1'b1;
    Req_we     = we;
    Req_rd_sel = rd;
    Req_addr   = addr;
    Req_wdata  = wd;
    check({tag, "_req_ready"}, Req_ready, 1);
    step();
    Req_valid = 1'b0;
  endtask

  // Called in the first RESP cycle with Rsp_ready high.
  task automatic finish_rsp(input string tag, input logic [31:0] rdata, input logic err);
    check({tag, "_rsp_valid"}, Rsp_valid, 1);
    check({tag, "_rsp_rdata"}, Rsp_rdata, rdata);
    check({tag, "_rsp_err"}, Rsp_err, err);
    check({tag, "_busy"}, Req_ready, 0);
    step();
    check({tag, "_rsp_drop"}, Rsp_valid, 0);
  endtask

  task automatic store(input string tag, input logic [1:0] we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [9:0] exp_waddr,
                       input logic [3:0] exp_be, input logic [31:0] exp_wd);
    send(tag, we, 3'd0, addr, wd);
    check({tag, "_sram_en"}, Sram_en, 1);
    check({tag, "_sram_addr"}, Sram_addr, exp_waddr);
    check({tag, "_sram_we"}, Sram_we, exp_be);
    check({tag, "_sram_wdata"}, Sram_wdata, exp_wd);
    check({tag, "_early_valid"}, Rsp_valid, 0);
    step();
    finish_rsp(tag, 32'd0, 1'b0);
  endtask

  task automatic load(input string tag, input logic [2:0] rd, input logic [31:0] addr,
                      input logic [9:0] exp_waddr, input logic [31:0] exp_data);
    send(tag, 2'd0, rd, addr, 32'h0);
    check({tag, "_sram_en"}, Sram_en, 1);
    check({tag, "_sram_we"}, Sram_we, 0);
    check({tag, "_sram_addr"}, Sram_addr, exp_waddr);
    step();
    check({tag, "_latch_valid"}, Rsp_valid, 0);
    check({tag, "_latch_en"}, Sram_en, 0);
    step();
    finish_rsp(tag, exp_data, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'd0;
    mem[8]  = 32'h1234_5678;
    mem[16] = 32'hCAFE_F00D;

    #3;
    check("rst_req_ready", Req_ready, 1);
    check("rst_rsp_valid", Rsp_valid, 0);
    check("rst_rsp_rdata", Rsp_rdata, 0);
    check("rst_rsp_err", Rsp_err, 0);
    check("rst_sram_en", Sram_en, 0);
    check("rst_sram_we", Sram_we, 0);
    check("rst_sram_addr", Sram_addr, 0);
    check("rst_sram_wdata", Sram_wdata, 0);
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    step();

    // Word store, then aliased reads: rd_sel 7 acts as word, bit 12 wraps away.
    store("sw10", 2'd3, 32'h10, 32'hDEAD_BEEF, 10'd4, 4'b1111, 32'hDEAD_BEEF);
    load("lw7_wrap", 3'd7, 32'h1010, 10'd4, 32'hDEAD_BEEF);

    store("sb13", 2'd1, 32'h13, 32'h0000_00A5, 10'd4, 4'b1000, 32'hA5A5_A5A5);
    load("lb13", 3'd1, 32'h13, 10'd4, 32'hFFFF_FFA5);
    load("lbu13", 3'd3, 32'h13, 10'd4, 32'h0000_00A5);
    load("lb11", 3'd1, 32'h11, 10'd4, 32'hFFFF_FFBE);

    store("sh22", 2'd2, 32'h22, 32'h0000_8001, 10'd8, 4'b1100, 32'h8001_8001);
    load("lh22", 3'd2, 32'h22, 10'd8, 32'hFFFF_8001);
    load("lhu22", 3'd4, 32'h22, 10'd8, 32'h0000_8001);
    load("lw20", 3'd0, 32'h20, 10'd8, 32'h8001_5678);
    load("lh20", 3'd2, 32'h20, 10'd8, 32'h0000_5678);

    // Misaligned requests answer next cycle without touching the SRAM.
    en_snap = en_count;
    send("lw06", 2'd0, 3'd0, 32'h06, 32'h0);
    check("lw06_sram_en", Sram_en, 0);
    finish_rsp("lw06", 32'd0, 1'b1);
    send("sh05", 2'd2, 3'd0, 32'h05, 32'hFFFF);
    check("sh05_sram_en", Sram_en, 0);
    finish_rsp("sh05", 32'd0, 1'b1);
    send("lhu01", 2'd0, 3'd4, 32'h01, 32'h0);
    finish_rsp("lhu01", 32'd0, 1'b1);
    check("mis_no_sram", en_count, en_snap);
    check("mem4_intact", mem[4], 32'hA5AD_BEEF);

    // Back-pressure: response held for 5 cycles while another request waits.
    Rsp_ready = 1'b0;
    send("bp_lbu", 2'd0, 3'd3, 32'h13, 32'h0);
    step();
    step();
    Req_valid  = 1'b1;
    Req_we     = 2'd0;
    Req_rd_sel = 3'd0;
    Req_addr   = 32'h10;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", Rsp_valid, 1);
      check("bp_rdata", Rsp_rdata, 32'h0000_00A5);
      check("bp_req_ready", Req_ready, 0);
      step();
    end
    Rsp_ready = 1'b1;
    check("bp_hold_last", Rsp_valid, 1);
    step();
    check("bp_drop", Rsp_valid, 0);
    check("bp_ready_back", Req_ready, 1);
    step();
    Req_valid = 1'b0;
    check("bp_next_en", Sram_en, 1);
    check("bp_next_addr", Sram_addr, 10'd4);
    step();
    step();
    finish_rsp("bp_next", 32'hA5AD_BEEF, 1'b0);

    // Reset in the middle of a store's ACCESS cycle must abort the write.
    send("rst_sw", 2'd3, 3'd0, 32'h40, 32'h3333_4444);
    check("rst_sw_en", Sram_en, 1);
    #2;
    Rst_n = 1'b0;
    #1;
    check("ra_sram_en", Sram_en, 0);
    check("ra_sram_we", Sram_we, 0);
    check("ra_sram_addr", Sram_addr, 0);
    check("ra_sram_wdata", Sram_wdata, 0);
    check("ra_rsp_valid", Rsp_valid, 0);
    check("ra_rsp_rdata", Rsp_rdata, 0);
    check("ra_rsp_err", Rsp_err, 0);
    check("ra_req_ready", Req_ready, 1);
    @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    step();
    check("ra_ready_after", Req_ready, 1);
    load("ra_lw40", 3'd0, 32'h40, 10'd16, 32'hCAFE_F00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
